audio_adc_rx: RTL
=================

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 Parameter: DW, 16, sample width in bits captured per channel.
REQ-002 Port: clk  input  1  system clock (28 MHz audio domain clock).
REQ-003 Port: rst  input  1  reset; synchronous, active-high; one clock domain only.
REQ-004 Port: aud_bclk  input  1  codec bit clock; asynchronous to clk.
REQ-005 Port: aud_adclrck  input  1  ADC LR clock; low = left, high = right; asynchronous.
REQ-006 Port: aud_adcdat  input  1  ADC serial data, I2S format, MSB first; asynchronous.
REQ-007 Port: ldata  output  DW  left sample of the held pair.
REQ-008 Port: rdata  output  DW  right sample of the held pair.
REQ-009 Port: out_valid  output  1  held pair is available.
REQ-010 Port: out_ready  input  1  consumer accepts the held pair.
REQ-011 Port: overrun  output  1  one-cycle pulse when an unaccepted pair is overwritten.
REQ-012 Port: frame_err  output  1  one-cycle pulse when a channel word is truncated.

Function
REQ-013 Each of aud_bclk, aud_adclrck and aud_adcdat shall pass through a 2-flop synchronizer in clk before any other use.
REQ-014 The block shall keep a third register on synchronized bclk and treat a 0->1 transition as a bit event (one clk-wide strobe).
REQ-015 On each bit event the block shall sample synchronized lrck and data, and register the sampled lrck as lrck_prev.
REQ-016 A bit event with sampled lrck != lrck_prev shall be an LR edge; that bit is the I2S delay slot and shall not be shifted in.
REQ-017 States: HUNT, SHIFT, PAD.
REQ-018 HUNT: wait for an LR edge to low (left); then go to SHIFT with bit counter = 0 and channel = left. LR edges to high in HUNT shall be ignored.
REQ-019 SHIFT: on each non-edge bit event, shift data into the channel shift register MSB first and increment the counter; on the DW-th bit, store the word and go to PAD.
REQ-020 PAD: ignore bit events until the next LR edge; bits beyond DW are discarded.
REQ-021 An LR edge in PAD shall start the next channel per sampled lrck: go to SHIFT, counter = 0.
REQ-022 An LR edge in SHIFT before DW bits are captured shall pulse frame_err for 1 clk, discard the partial word and any stored left word of that frame, and restart SHIFT for the new channel.
REQ-023 A pair is complete when a right word is stored and a left word was stored in the immediately preceding left slot; a right word without a valid left shall be discarded silently.
REQ-024 On pair completion, ldata and rdata shall load and out_valid shall be 1 on the clk after the bit event carrying the right LSB (latency 1 clk from that strobe).
REQ-025 Handshake: the held pair is consumed in a cycle with out_valid = 1 and out_ready = 1; out_valid then clears the next cycle unless a new pair loads in that same cycle.
REQ-026 out_valid = 1 with out_ready = 0 shall hold ldata and rdata stable.
REQ-027 New pair while out_valid = 1 and out_ready = 0: overwrite ldata and rdata, keep out_valid = 1, pulse overrun for 1 clk.
REQ-028 New pair in the same cycle as an accept: no overrun; the new pair loads and out_valid stays 1.
REQ-029 Operating constraint: bclk high and low phases each ≥ 3 clk periods; otherwise behaviour is undefined.

Reset
REQ-030 While rst = 1 at a clk edge: state = HUNT, counter = 0, stored-left flag = 0, ldata = 0, rdata = 0, out_valid = 0, overrun = 0, frame_err = 0, synchronizer and lrck_prev registers = 0.
REQ-031 Reset asserted mid-word shall discard all partial data; after release, no pair shall be emitted before a fresh left slot starting from HUNT.

Verification
REQ-032 DW = 16, 32-bit slots, bclk = clk/8: left 0xA55A, right 0x1234, out_ready = 1 -> ldata = 0xA55A, rdata = 0x1234, out_valid high for 1 clk, 1 clk after the right-LSB bit event.
REQ-033 Two frames (0x0001/0x8000, then 0xFFFF/0x0000), out_ready = 0 throughout -> after frame 2, ldata = 0xFFFF, rdata = 0x0000, out_valid = 1, exactly one overrun pulse.
REQ-034 Left word truncated to 10 bits by an early LR edge -> one frame_err pulse; that frame's right word is not emitted; the next full frame is emitted correctly.
REQ-035 Reset pulsed during bit 7 of a right word -> all outputs 0; the first emitted pair comes from the first complete left+right frame after release.
REQ-036 Stream starts in the right slot after reset -> the right word is ignored (HUNT); the first pair is the following left+right; no frame_err.

Source files
------------

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S ADC receiver capturing left/right pairs into a valid/ready holding register.
module audio_adc_rx #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          aud_bclk,
    input  logic          aud_adclrck,
    input  logic          aud_adcdat,
    output logic [DW-1:0] ldata,
    output logic [DW-1:0] rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    output logic          frame_err
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {HUNT, SHIFT, PAD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    bclk_q, bclk_d;
    logic [1:0]    lrck_q, lrck_d;
    logic [1:0]    dat_q, dat_d;
    logic          lrck_prev_q, lrck_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chan_q, chan_d;
    logic          lvalid_q, lvalid_d;
    logic [DW-1:0] sr_q, sr_d;
    logic [DW-1:0] lword_q, lword_d;
    logic [DW-1:0] ldata_q, ldata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          bit_ev, lr, din, lr_edge, load;
    logic [DW-1:0] shifted;

    always_comb begin
        bclk_d      = {bclk_q[1:0], aud_bclk};
        lrck_d      = {lrck_q[0], aud_adclrck};
        dat_d       = {dat_q[0], aud_adcdat};
        bit_ev      = bclk_q[1] & ~bclk_q[2];
        lr          = lrck_q[1];
        din         = dat_q[1];
        lr_edge     = bit_ev & (lr != lrck_prev_q);
        lrck_prev_d = bit_ev ? lr : lrck_prev_q;
        shifted     = (sr_q << 1) | DW'(din);
        state_d     = state_q;
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        lvalid_d    = lvalid_q;
        sr_d        = sr_q;
        lword_d     = lword_q;
        load        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            HUNT: begin
                if (lr_edge && !lr) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    chan_d   = 1'b0;
                    lvalid_d = 1'b0;
                end
            end
            SHIFT: begin
                if (lr_edge) begin
                    frame_err_d = 1'b1;
                    lvalid_d    = 1'b0;
                    cnt_d       = '0;
                    chan_d      = lr;
                end else if (bit_ev) begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d = PAD;
                        if (!chan_q) begin
                            lword_d  = shifted;
                            lvalid_d = 1'b1;
                        end else begin
                            load     = lvalid_q;
                            lvalid_d = 1'b0;
                        end
                    end
                end
            end
            PAD: begin
                if (lr_edge) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    chan_d   = lr;
                    lvalid_d = lr ? lvalid_q : 1'b0;
                end
            end
            default: state_d = HUNT;
        endcase
        // a pair loading in the accept cycle replaces the consumed one without overrun
        ldata_d     = load ? lword_q : ldata_q;
        rdata_d     = load ? shifted : rdata_q;
        out_valid_d = load | (out_valid_q & ~out_ready);
        overrun_d   = load & out_valid_q & ~out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            bclk_q      <= '0;
            lrck_q      <= '0;
            dat_q       <= '0;
            lrck_prev_q <= 1'b0;
            cnt_q       <= '0;
            chan_q      <= 1'b0;
            lvalid_q    <= 1'b0;
            sr_q        <= '0;
            lword_q     <= '0;
            ldata_q     <= '0;
            rdata_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            lrck_prev_q <= lrck_prev_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            lvalid_q    <= lvalid_d;
            sr_q        <= sr_d;
            lword_q     <= lword_d;
            ldata_q     <= ldata_d;
            rdata_q     <= rdata_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ldata     = ldata_q;
    assign rdata     = rdata_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
endmodule
